// File: rtl/axi_master_arbiter.sv
// Two-requester AXI4 master-port arbiter (IFU = requester 0, LSU = requester 1).
// Round-robin grant held until the owned transaction's final response handshake.
module axi_master_arbiter #(
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int CNT_WIDTH      = 11
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ifu_req,
   input  logic       lsu_req,
   input  logic       lsu_write,
   output logic       ifu_grant,
   output logic       lsu_grant,
   output logic       sel,
   input  logic       arvalid,
   input  logic       arready,
   input  logic       rvalid,
   input  logic       rready,
   input  logic       rlast,
   input  logic [1:0] rresp,
   input  logic       awvalid,
   input  logic       awready,
   input  logic       wvalid,
   input  logic       wready,
   input  logic       wlast,
   input  logic       bvalid,
   input  logic       bready,
   input  logic [1:0] bresp,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic       timeout
);

   typedef enum logic [2:0] {IDLE, ADDR_RD, DATA_RD, ADDR_WR, RESP_WR} state_t;

   state_t state_reg;
   logic   last_owner_reg;
   logic   aw_done_reg;
   logic   w_done_reg;

   logic ar_fire, r_fire, aw_fire, w_fire, w_last_fire, b_fire, any_fire;
   logic arb_go, pick_lsu, ar_adv, rd_end, wr_addr_end, wr_end, state_change;

   assign ar_fire     = arvalid & arready;
   assign r_fire      = rvalid & rready;
   assign aw_fire     = awvalid & awready;
   assign w_fire      = wvalid & wready;
   assign w_last_fire = w_fire & wlast;
   assign b_fire      = bvalid & bready;
   assign any_fire    = ar_fire | r_fire | aw_fire | w_fire | b_fire;

   // On a tie the requester that did not own the port last time wins.
   assign arb_go      = (state_reg == IDLE) && (ifu_req || lsu_req);
   assign pick_lsu    = lsu_req && (!ifu_req || !last_owner_reg);
   assign ar_adv      = (state_reg == ADDR_RD) && ar_fire;
   assign rd_end      = (state_reg == DATA_RD) && r_fire && rlast;
   assign wr_addr_end = (state_reg == ADDR_WR) && (aw_done_reg || aw_fire)
                        && (w_done_reg || w_last_fire);
   assign wr_end      = (state_reg == RESP_WR) && b_fire;
   assign state_change = arb_go | ar_adv | rd_end | wr_addr_end | wr_end;

   assign busy = (state_reg != IDLE);
   assign done = rd_end | wr_end;
   assign err  = (rd_end && (rresp != 2'b00)) || (wr_end && (bresp != 2'b00));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= IDLE;
         ifu_grant      <= 1'b0;
         lsu_grant      <= 1'b0;
         sel            <= 1'b0;
         last_owner_reg <= 1'b1;
         aw_done_reg    <= 1'b0;
         w_done_reg     <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (arb_go) begin
                  ifu_grant      <= !pick_lsu;
                  lsu_grant      <= pick_lsu;
                  sel            <= pick_lsu;
                  last_owner_reg <= pick_lsu;
                  state_reg      <= (pick_lsu && lsu_write) ? ADDR_WR : ADDR_RD;
               end
            end
            ADDR_RD: begin
               if (ar_fire) state_reg <= DATA_RD;
            end
            DATA_RD: begin
               if (rd_end) begin
                  state_reg <= IDLE;
                  ifu_grant <= 1'b0;
                  lsu_grant <= 1'b0;
                  sel       <= 1'b0;
               end
            end
            ADDR_WR: begin
               // AW and the last W beat may complete in either order or together.
               if (wr_addr_end) begin
                  state_reg   <= RESP_WR;
                  aw_done_reg <= 1'b0;
                  w_done_reg  <= 1'b0;
               end else begin
                  if (aw_fire)     aw_done_reg <= 1'b1;
                  if (w_last_fire) w_done_reg  <= 1'b1;
               end
            end
            RESP_WR: begin
               if (wr_end) begin
                  state_reg <= IDLE;
                  ifu_grant <= 1'b0;
                  lsu_grant <= 1'b0;
                  sel       <= 1'b0;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   generate
      if (TIMEOUT_CYCLES > 0) begin : g_wdog
         localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES);
         logic [CNT_WIDTH-1:0] wdog_reg;
         logic                 timeout_reg;

         // Stalled-owner watchdog: any progress clears it, the flag is sticky.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               wdog_reg    <= '0;
               timeout_reg <= 1'b0;
            end else if (state_change || any_fire || !busy) begin
               wdog_reg <= '0;
            end else if (wdog_reg != LIMIT) begin
               wdog_reg <= wdog_reg + 1'b1;
               if (wdog_reg == LIMIT - 1'b1) timeout_reg <= 1'b1;
            end
         end
         assign timeout = timeout_reg;
      end else begin : g_no_wdog
         assign timeout = 1'b0;
      end
   endgenerate

endmodule
